// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_KILL = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Harvard instruction-memory request/ready handshake between fetch and memory.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   IMemReq;
    logic [ADDR_WIDTH-1:0]  IMemAddr;
    logic                   IMemReady;
    logic [INSTR_WIDTH-1:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRData
    );
endinterface

// File: rtl/fetch_stage_next_pc.sv
// Next-PC select: jump over branch over sequential advance over hold.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  advance,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] pc_jump,
    input  logic                  branch,
    input  logic [ADDR_WIDTH-1:0] pc_branch,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + ADDR_WIDTH'(PC_INCR);

    // Redirect targets are forced word aligned.
    always_comb begin
        next_pc = pc;
        if (jump) begin
            next_pc = {pc_jump[ADDR_WIDTH-1:2], 2'b00};
        end else if (branch) begin
            next_pc = {pc_branch[ADDR_WIDTH-1:2], 2'b00};
        end else if (advance) begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem handshake, stall/redirect handling.
// Optional one-entry skid buffer enabled by FETCH_SKID_BUFFER_EN.
//   state  | meaning
//   S_BOOT | one idle cycle after reset release
//   S_REQ  | issuing / waiting on a fetch at PC
//   S_KILL | waiting out a redirected-away request, data discarded
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   StallF,
    input  logic                   PCSrcD,
    input  logic [ADDR_WIDTH-1:0]  PCBranchD,
    input  logic                   JumpD,
    input  logic [ADDR_WIDTH-1:0]  PCJumpD,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] InstrF,
    output logic [ADDR_WIDTH-1:0]  PCPlus4F,
    output logic                   InstrValidF,
    output logic                   FetchBusyF
);

    fetch_state_t state, state_n;

    logic [ADDR_WIDTH-1:0]  pc, pc_n, pc_plus4, req_addr;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  pcplus4_q;
    logic                   valid_q;
    logic                   pending, pending_n;
    logic                   kill, kill_n;
    logic                   req, done, advance, capture, bubble, redirect;
    logic                   skid_full;

`ifdef FETCH_SKID_BUFFER_EN
    logic                   skid_valid, skid_load, skid_drain;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [ADDR_WIDTH-1:0]  skid_pc4;
    assign skid_full = skid_valid;
`else
    assign skid_full = 1'b0;
`endif

    assign redirect = JumpD | PCSrcD;

    fetch_next_pc #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc (
        .pc        (pc),
        .advance   (advance),
        .jump      (JumpD),
        .pc_jump   (PCJumpD),
        .branch    (PCSrcD),
        .pc_branch (PCBranchD),
        .next_pc   (pc_n),
        .pc_plus4  (pc_plus4)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_BOOT;
            pending <= 1'b0;
            kill    <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            kill    <= kill_n;
        end
    end

    always_comb begin
        state_n   = state;
        req       = 1'b0;
        done      = 1'b0;
        pending_n = pending;
        kill_n    = kill;
        advance   = 1'b0;
        capture   = 1'b0;
        bubble    = 1'b0;
`ifdef FETCH_SKID_BUFFER_EN
        skid_load  = 1'b0;
        skid_drain = 1'b0;
`endif
        unique case (state)
            S_BOOT: state_n = S_REQ;
            S_REQ: begin
                // An issued request is never withdrawn, whatever StallF does.
                req  = pending | (~StallF & ~skid_full);
                done = req & imem.IMemReady;
                if (done) begin
                    pending_n = 1'b0;
                end else if (req) begin
                    pending_n = 1'b1;
                end
                if (redirect) begin
                    bubble = ~StallF;
                    if (req & ~imem.IMemReady) begin
                        state_n = S_KILL;
                        kill_n  = 1'b1;
                    end
                end else if (StallF) begin
`ifdef FETCH_SKID_BUFFER_EN
                    if (done) begin
                        skid_load = 1'b1;
                        advance   = 1'b1;
                    end
`endif
                end else if (skid_full) begin
`ifdef FETCH_SKID_BUFFER_EN
                    skid_drain = 1'b1;
`endif
                end else if (done & ~kill) begin
                    capture = 1'b1;
                    advance = 1'b1;
                end else begin
                    bubble = 1'b1;
                end
            end
            S_KILL: begin
                req    = 1'b1;
                done   = imem.IMemReady;
                bubble = ~StallF;
                if (done) begin
                    state_n   = S_REQ;
                    kill_n    = 1'b0;
                    pending_n = 1'b0;
                end
            end
            default: state_n = S_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            instr_q   <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc <= pc_n;
            if (req & ~pending) begin
                req_addr <= pc;
            end
            if (capture) begin
                instr_q   <= imem.IMemRData;
                pcplus4_q <= pc_plus4;
                valid_q   <= 1'b1;
            end
`ifdef FETCH_SKID_BUFFER_EN
            else if (skid_drain) begin
                instr_q   <= skid_instr;
                pcplus4_q <= skid_pc4;
                valid_q   <= 1'b1;
            end
`endif
            else if (bubble) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_SKID_BUFFER_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else if (redirect) begin
            skid_valid <= 1'b0;
        end else if (skid_load) begin
            skid_valid <= 1'b1;
            skid_instr <= imem.IMemRData;
            skid_pc4   <= pc_plus4;
        end else if (skid_drain) begin
            skid_valid <= 1'b0;
        end
    end
`endif

    assign imem.IMemReq  = req;
    assign imem.IMemAddr = pending ? req_addr : pc;
    assign InstrF        = instr_q;
    assign PCPlus4F      = pcplus4_q;
    assign InstrValidF   = valid_q;
    assign FetchBusyF    = req & ~imem.IMemReady;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order fetch-stream model and variable-latency memory.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcD = 1'b0;
    logic        JumpD = 1'b0;
    logic [31:0] PCBranchD = '0;
    logic [31:0] PCJumpD = '0;
    logic [31:0] InstrF, PCPlus4F;
    logic        InstrValidF, FetchBusyF;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    int cnt = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .JumpD       (JumpD),
        .PCJumpD     (PCJumpD),
        .imem        (imem_bus),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF),
        .FetchBusyF  (FetchBusyF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_000A;
        if (a == 32'h4) return 32'h2002_000B;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: ready in the lat-th cycle a request is held.
    initial begin
        int nxt;
        imem_bus.IMemReady = 1'b0;
        imem_bus.IMemRData = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (imem_bus.IMemReq === 1'b1 && cnt + 1 >= lat) begin
                imem_bus.IMemReady = 1'b1;
                imem_bus.IMemRData = mem_word(imem_bus.IMemAddr);
            end else begin
                imem_bus.IMemReady = 1'b0;
                imem_bus.IMemRData = 32'hDEAD_BEEF;
            end
            if (imem_bus.IMemReq !== 1'b1 || imem_bus.IMemReady) nxt = 0;
            else nxt = cnt + 1;
            @(posedge CLK);
            cnt = nxt;
        end
    end

    // Stream model: valid instructions must arrive in program order from the
    // current fetch target; redirects restart the stream at the aligned target.
    logic [31:0] exp_addr = RESET_PC;
    logic        prev_out = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        pre_rst, pre_stall, pre_req, pre_ready, pre_redir, pre_valid;
    logic [31:0] pre_target, pre_instr, pre_pc4;

    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                check("busy", {31'd0, FetchBusyF}, {31'd0, imem_bus.IMemReq & ~imem_bus.IMemReady});
                if (imem_bus.IMemReq) check("align", {30'd0, imem_bus.IMemAddr[1:0]}, 32'd0);
                if (prev_out) begin
                    check("req_hold", {31'd0, imem_bus.IMemReq}, 32'd1);
                    check("addr_hold", imem_bus.IMemAddr, prev_addr);
                end else if (StallF) begin
                    check("stall_noreq", {31'd0, imem_bus.IMemReq}, 32'd0);
                end
            end
            pre_rst    = RST;
            pre_stall  = StallF;
            pre_req    = imem_bus.IMemReq;
            pre_ready  = imem_bus.IMemReady;
            pre_redir  = JumpD | PCSrcD;
            pre_target = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
            pre_instr  = InstrF;
            pre_pc4    = PCPlus4F;
            pre_valid  = InstrValidF;
            prev_out   = RST & imem_bus.IMemReq & ~imem_bus.IMemReady;
            prev_addr  = imem_bus.IMemAddr;
            @(posedge CLK);
            #1;
            if (!RST || !pre_rst) begin
                if (!RST) begin
                    check("rst_valid", {31'd0, InstrValidF}, 32'd0);
                    check("rst_instr", InstrF, 32'd0);
                end
                exp_addr = RESET_PC;
                prev_out = 1'b0;
            end else begin
                if (pre_stall) begin
                    check("stall_instr", InstrF, pre_instr);
                    check("stall_pc4", PCPlus4F, pre_pc4);
                    check("stall_valid", {31'd0, InstrValidF}, {31'd0, pre_valid});
                end else begin
                    if (pre_redir) check("redir_bubble", {31'd0, InstrValidF}, 32'd0);
`ifndef FETCH_SKID_BUFFER_EN
                    if (!(pre_req & pre_ready)) check("bubble", {31'd0, InstrValidF}, 32'd0);
`endif
                    if (InstrValidF) begin
                        check("stream_pc4", PCPlus4F, exp_addr + 32'd4);
                        check("stream_instr", InstrF, mem_word(exp_addr));
                        exp_addr = exp_addr + 32'd4;
                    end
                end
                if (pre_redir) exp_addr = pre_target;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic mid();
        @(negedge CLK);
        #3;
    endtask

    initial begin
        #1 RST = 1'b0;
        repeat (3) tick();
        check("reset_req", {31'd0, imem_bus.IMemReq}, 32'd0);
        check("reset_valid", {31'd0, InstrValidF}, 32'd0);
        check("reset_instr", InstrF, 32'd0);
        check("reset_pc4", PCPlus4F, 32'd0);
        RST = 1'b1;
        mid();  check("boot_noreq", {31'd0, imem_bus.IMemReq}, 32'd0);
        tick(); mid();
        check("first_req", {31'd0, imem_bus.IMemReq}, 32'd1);
        check("first_addr", imem_bus.IMemAddr, RESET_PC);
        tick();
        check("zw_instr0", InstrF, 32'h2001_000A);
        check("zw_pc4_0", PCPlus4F, 32'h4);
        check("zw_valid0", {31'd0, InstrValidF}, 32'd1);
        mid();  check("zw_addr1", imem_bus.IMemAddr, 32'h4);
        tick();
        check("zw_instr1", InstrF, 32'h2002_000B);
        check("zw_pc4_1", PCPlus4F, 32'h8);
        check("zw_valid1", {31'd0, InstrValidF}, 32'd1);
        tick();
        check("zw_instr2", InstrF, 32'hC0DE_0008);
        check("zw_pc4_2", PCPlus4F, 32'hC);
        lat = 3;
        mid();  check("c_addr", imem_bus.IMemAddr, 32'hC);
        check("c_busy", {31'd0, FetchBusyF}, 32'd1);
        tick();
        StallF = 1'b1;
        check("c_bubble", {31'd0, InstrValidF}, 32'd0);
        mid();  check("c_held_req", {31'd0, imem_bus.IMemReq}, 32'd1);
        check("c_held_addr", imem_bus.IMemAddr, 32'hC);
        tick(); mid();
        check("c_done_busy", {31'd0, FetchBusyF}, 32'd0);
        check("c_done_addr", imem_bus.IMemAddr, 32'hC);
        tick(); mid();
        check("stall_req_off", {31'd0, imem_bus.IMemReq}, 32'd0);
        tick();
        tick();
        check("frozen_instr", InstrF, 32'hC0DE_0008);
        check("frozen_pc4", PCPlus4F, 32'hC);
        check("frozen_valid", {31'd0, InstrValidF}, 32'd0);
        StallF = 1'b0;
        lat = 1;
        mid();
`ifdef FETCH_SKID_BUFFER_EN
        check("skid_noreq", {31'd0, imem_bus.IMemReq}, 32'd0);
`else
        check("refetch_req", {31'd0, imem_bus.IMemReq}, 32'd1);
        check("refetch_addr", imem_bus.IMemAddr, 32'hC);
`endif
        tick();
        check("c_instr", InstrF, 32'hC0DE_000C);
        check("c_pc4", PCPlus4F, 32'h10);
        check("c_valid", {31'd0, InstrValidF}, 32'd1);
        lat = 3;
        mid();  check("l3_addr0", imem_bus.IMemAddr, 32'h10);
        check("l3_busy0", {31'd0, FetchBusyF}, 32'd1);
        tick();
        check("l3_bub1", {31'd0, InstrValidF}, 32'd0);
        mid();  check("l3_addr1", imem_bus.IMemAddr, 32'h10);
        check("l3_busy1", {31'd0, FetchBusyF}, 32'd1);
        tick();
        check("l3_bub2", {31'd0, InstrValidF}, 32'd0);
        mid();  check("l3_addr2", imem_bus.IMemAddr, 32'h10);
        check("l3_busy2", {31'd0, FetchBusyF}, 32'd0);
        tick();
        check("l3_instr", InstrF, 32'hC0DE_0010);
        check("l3_pc4", PCPlus4F, 32'h14);
        tick();
        JumpD = 1'b1;
        PCJumpD = 32'h0000_0100;
        mid();  check("jmp_old_addr", imem_bus.IMemAddr, 32'h14);
        tick();
        JumpD = 1'b0;
        lat = 1;
        mid();  check("kill_req", {31'd0, imem_bus.IMemReq}, 32'd1);
        check("kill_addr", imem_bus.IMemAddr, 32'h14);
        tick();
        check("kill_bubble", {31'd0, InstrValidF}, 32'd0);
        mid();  check("jmp_addr", imem_bus.IMemAddr, 32'h100);
        tick();
        check("jmp_instr", InstrF, 32'hC0DE_0100);
        check("jmp_pc4", PCPlus4F, 32'h104);
        PCSrcD = 1'b1;
        PCBranchD = 32'hFFFF_FFFF;
        tick();
        PCSrcD = 1'b0;
        check("br_discard", {31'd0, InstrValidF}, 32'd0);
        mid();  check("br_addr", imem_bus.IMemAddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_instr", InstrF, 32'hC0DE_FFFC);
        check("wrap_pc4", PCPlus4F, 32'h0);
        check("wrap_valid", {31'd0, InstrValidF}, 32'd1);
        mid();  check("wrap_addr", imem_bus.IMemAddr, 32'h0);
        tick();
        check("wrap_next", InstrF, 32'h2001_000A);
        lat = 3;
        mid();  check("mid_busy", {31'd0, FetchBusyF}, 32'd1);
        #1 RST = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_bus.IMemReq}, 32'd0);
        check("arst_valid", {31'd0, InstrValidF}, 32'd0);
        check("arst_busy", {31'd0, FetchBusyF}, 32'd0);
        tick();
        tick();
        lat = 1;
        RST = 1'b1;
        mid();  check("rel_noreq", {31'd0, imem_bus.IMemReq}, 32'd0);
        tick(); mid();
        check("rel_req", {31'd0, imem_bus.IMemReq}, 32'd1);
        check("rel_addr", imem_bus.IMemAddr, RESET_PC);
        tick();
        check("rel_instr", InstrF, 32'h2001_000A);
        check("rel_valid", {31'd0, InstrValidF}, 32'd1);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that produces the F-side inputs of the Fetch-to-Decode pipeline register: InstrF, PCPlus4F and a valid bit.
- Owns the PC register and the Harvard instruction-memory request/ready handshake, with variable memory latency.
- Honours stall requests from the hazard unit and branch/jump redirects from Decode.
- Drives FetchBusyF back to the hazard unit while a memory access is outstanding.

Parameters:
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit: hold fetch outputs, issue no new request.
- PCSrcD  in  1  taken branch in Decode.
- PCBranchD  in  ADDR_WIDTH  branch target.
- JumpD  in  1  jump in Decode; has priority over PCSrcD.
- PCJumpD  in  ADDR_WIDTH  jump target.
- IMemReq  out  1  instruction memory request.
- IMemAddr  out  ADDR_WIDTH  request address (word aligned).
- IMemReady  in  1  response valid this cycle; may assert in the same cycle as IMemReq.
- IMemRData  in  INSTR_WIDTH  instruction data, valid when IMemReady=1.
- InstrF  out  INSTR_WIDTH  fetched instruction to the F/D register.
- PCPlus4F  out  ADDR_WIDTH  address of InstrF + 4.
- InstrValidF  out  1  InstrF is a real instruction; 0 means bubble.
- FetchBusyF  out  1  =IMemReq & ~IMemReady, stall request to the hazard unit.

Behaviour:
- Reset (RST=0, asynchronous): PC=RESET_PC, state=S_BOOT, InstrF=0, PCPlus4F=0, InstrValidF=0, IMemReq=0, kill flag=0.
- S_BOOT: one cycle after reset release with no request, then S_REQ.
- S_REQ:
  - IMemReq = ~StallF; IMemAddr=PC.
  - If StallF=1 and nothing is outstanding, stay in S_REQ with no request.
  - Once a request has been issued and has not completed, IMemReq and IMemAddr stay stable until IMemReady, regardless of StallF.
- Completion (IMemReq & IMemReady), StallF=0, no kill, no redirect:
  - Next edge: InstrF=IMemRData, PCPlus4F=PC+4, InstrValidF=1, PC=PC+4.
  - Zero-wait memory gives one instruction per cycle; latency is 1 cycle from request to outputs.
- Any cycle with StallF=0 and no completion: InstrValidF=0 (bubble); InstrF and PCPlus4F hold.
- StallF=1: InstrF, PCPlus4F and InstrValidF hold unchanged.
- Completion while StallF=1: data is dropped and PC is not advanced; the same PC is refetched after StallF falls. Overridden by the optional feature.
- Redirect (JumpD | PCSrcD):
  - Target is PCJumpD if JumpD, else PCBranchD.
  - PC=target at the next edge.
  - If a request is outstanding and not completing this cycle, set kill and go to S_KILL.
  - A completion in the same cycle as the redirect is discarded (InstrValidF=0).
- S_KILL: keep the old request until IMemReady, discard the data, clear kill, return to S_REQ at the target. A further redirect in S_KILL updates PC only.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC + 4 wraps to 0.
- Bits [1:0] of redirect targets are forced to 0.
- Reset mid-transaction: the request is abandoned immediately. Memory must tolerate IMemReq dropping.

Optional Feature:
- Macro FETCH_SKID_BUFFER_EN.
- Defined:
  - Adds a one-entry skid buffer (instruction plus PC+4).
  - A completion while StallF=1 is stored in the buffer and PC advances.
  - When StallF falls, the buffer drains to the outputs before any new request is issued.
  - A redirect clears the buffer.
  - While the buffer is full, no request is issued.
- Undefined: drop-and-refetch behaviour as above.

Decomposition:
- Package fetch_pkg: state enum (S_BOOT, S_REQ, S_KILL), the constant for the +4 increment, and the default RESET_PC.
- One natural sub-module: fetch_next_pc, combinational next-PC select (PC+4, branch, jump, hold).
- The skid buffer stays inline.

Test Plan:
- Reset release, zero-wait memory returning 0x2001_000A at 0x0 and 0x2002_000B at 0x4: InstrF values appear on consecutive cycles; PCPlus4F=0x4 then 0x8; InstrValidF=1 continuously.
- Memory with 3-cycle latency: IMemAddr held stable for 3 cycles; FetchBusyF=1 for 2 cycles; InstrValidF=0 bubbles until data arrives.
- JumpD=1, PCJumpD=0x0000_0100 during an outstanding 3-cycle request: old data discarded; next IMemAddr=0x100; no valid instruction from the old address.
- StallF=1 for 4 cycles after fetching 0x8: outputs frozen, IMemReq=0. Without FETCH_SKID_BUFFER_EN a stall arriving mid-request causes 0xC to be refetched; with it, 0xC is delivered from the buffer on the first unstalled cycle.
- PC=0xFFFF_FFFC with zero-wait memory: PCPlus4F=0x0 and the next IMemAddr=0x0.
- RST=0 asserted while IMemReq=1: IMemReq=0 and InstrValidF=0 asynchronously; after release, the first IMemAddr is RESET_PC one cycle later.
